// File: rtl/mul_pkg.sv
// Shared types and constants for the UART/SPI multiplier-sharing controller.
package mul_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;

    // Requester identifiers, also the encoding of grant_id
    localparam logic REQ_UART = 1'b0;
    localparam logic REQ_SPI  = 1'b1;

    // ST_PIPE is only reachable when MUL_PIPE_EN is defined
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_PIPE = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operands_t;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Request/response handshake bundle for the UART and SPI requesters.
interface mul_share_ctrl_if;
    import mul_pkg::*;

    logic              u_req_valid;
    logic              u_req_ready;
    logic [OP_W-1:0]   u_a;
    logic [OP_W-1:0]   u_b;
    logic              u_rsp_valid;
    logic              u_rsp_ready;
    logic [PROD_W-1:0] u_rsp_prod;

    logic              s_req_valid;
    logic              s_req_ready;
    logic [OP_W-1:0]   s_a;
    logic [OP_W-1:0]   s_b;
    logic              s_rsp_valid;
    logic              s_rsp_ready;
    logic [PROD_W-1:0] s_rsp_prod;

    // Controller side
    modport slave (
        input  u_req_valid, u_a, u_b, u_rsp_ready,
        input  s_req_valid, s_a, s_b, s_rsp_ready,
        output u_req_ready, u_rsp_valid, u_rsp_prod,
        output s_req_ready, s_rsp_valid, s_rsp_prod
    );

    // Requester side
    modport master (
        output u_req_valid, u_a, u_b, u_rsp_ready,
        output s_req_valid, s_a, s_b, s_rsp_ready,
        input  u_req_ready, u_rsp_valid, u_rsp_prod,
        input  s_req_ready, s_rsp_valid, s_rsp_prod
    );

endinterface

// File: rtl/i8bit_mul.sv
// Combinational 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built from 2x2 and 4x4 blocks.
module i8bit_mul
    import mul_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    // 2x2 vertical-and-crosswise cell
    function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
        logic t1, t2, t3, c1;
        t1 = x[1] & y[0];
        t2 = x[0] & y[1];
        t3 = x[1] & y[1];
        c1 = t1 & t2;
        return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
    endfunction

    // 4x4 from four 2x2 partials
    function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r0, r1, r2, r3;
        r0 = vedic2(x[1:0], y[1:0]);
        r1 = vedic2(x[3:2], y[1:0]);
        r2 = vedic2(x[1:0], y[3:2]);
        r3 = vedic2(x[3:2], y[3:2]);
        return {r3, 4'h0} + 8'({r1, 2'b00}) + 8'({r2, 2'b00}) + 8'(r0);
    endfunction

    logic [7:0] q0, q1, q2, q3;

    assign q0 = vedic4(a[3:0], b[3:0]);
    assign q1 = vedic4(a[7:4], b[3:0]);
    assign q2 = vedic4(a[3:0], b[7:4]);
    assign q3 = vedic4(a[7:4], b[7:4]);

    // 8x8 from four 4x4 partials
    assign p = {q3, 8'h00} + 16'({q1, 4'h0}) + 16'({q2, 4'h0}) + 16'(q0);

endmodule

// File: rtl/mul_share_ctrl.sv
// Time-shares one 8x8 multiplier between a UART and an SPI requester with
// round-robin arbitration. Define MUL_PIPE_EN to add a product register stage
// (PIPE state), raising accept-to-response latency from 2 to 3 cycles.
module mul_share_ctrl
    import mul_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    mul_share_ctrl_if.slave bus,
    output logic            busy,
    output logic            grant_id
);

    state_e            state_q, state_d;
    operands_t         ops_q, ops_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic              grant_q, grant_d;
    logic              prio_q, prio_d;
    logic              u_vld_q, u_vld_d;
    logic              s_vld_q, s_vld_d;
    logic              busy_q, busy_d;
    logic [PROD_W-1:0] mul_p;
    logic              accept_u, accept_s, owner_ready;
`ifdef MUL_PIPE_EN
    logic [PROD_W-1:0] pipe_q, pipe_d;
`endif

    i8bit_mul u_mul (
        .a (ops_q.a),
        .b (ops_q.b),
        .p (mul_p)
    );

    // Arbitration: single valid wins, ties go to prio_q; ready only in IDLE and out of reset
    always_comb begin
        accept_u = 1'b0;
        accept_s = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
            accept_u = bus.u_req_valid && (!bus.s_req_valid || (prio_q == REQ_UART));
            accept_s = bus.s_req_valid && (!bus.u_req_valid || (prio_q == REQ_SPI));
        end
    end

    assign owner_ready = (grant_q == REQ_SPI) ? bus.s_rsp_ready : bus.u_rsp_ready;

    // Next-state and datapath load logic
    always_comb begin
        state_d = state_q;
        ops_d   = ops_q;
        prod_d  = prod_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        u_vld_d = u_vld_q;
        s_vld_d = s_vld_q;
`ifdef MUL_PIPE_EN
        pipe_d  = pipe_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept_u || accept_s) begin
                    ops_d   = accept_s ? '{a: bus.s_a, b: bus.s_b} : '{a: bus.u_a, b: bus.u_b};
                    grant_d = accept_s ? REQ_SPI : REQ_UART;
                    prio_d  = accept_s ? REQ_UART : REQ_SPI;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
`ifdef MUL_PIPE_EN
                pipe_d  = mul_p;
                state_d = ST_PIPE;
`else
                prod_d  = mul_p;
                u_vld_d = (grant_q == REQ_UART);
                s_vld_d = (grant_q == REQ_SPI);
                state_d = ST_RESP;
`endif
            end
`ifdef MUL_PIPE_EN
            ST_PIPE: begin
                prod_d  = pipe_q;
                u_vld_d = (grant_q == REQ_UART);
                s_vld_d = (grant_q == REQ_SPI);
                state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (owner_ready) begin
                    u_vld_d = 1'b0;
                    s_vld_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                u_vld_d = 1'b0;
                s_vld_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ops_q   <= '0;
            prod_q  <= '0;
            grant_q <= REQ_UART;
            prio_q  <= REQ_UART;
            u_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MUL_PIPE_EN
            pipe_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
            prod_q  <= prod_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            u_vld_q <= u_vld_d;
            s_vld_q <= s_vld_d;
            busy_q  <= busy_d;
`ifdef MUL_PIPE_EN
            pipe_q  <= pipe_d;
`endif
        end
    end

    assign bus.u_req_ready = accept_u;
    assign bus.s_req_ready = accept_s;
    assign bus.u_rsp_valid = u_vld_q;
    assign bus.s_rsp_valid = s_vld_q;
    assign bus.u_rsp_prod  = prod_q;
    assign bus.s_rsp_prod  = prod_q;
    assign busy            = busy_q;
    assign grant_id        = grant_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl: directed cases with literal results,
// then randomized traffic checked every cycle against a transaction-level model.
// Honours MUL_PIPE_EN for the expected latency.
module tb_mul_share_ctrl;

`ifdef MUL_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic rst_n;
    logic busy;
    logic grant_id;

    mul_share_ctrl_if bus ();

    mul_share_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Transaction-level reference: one job in flight, result visible LAT cycles after accept
    bit          m_busy, m_owner, m_pref;
    int          m_rem;
    logic [15:0] m_prod, m_pend;
    bit          u_acc, s_acc;

    always @(negedge clk) begin
        bit eu, es, ev;
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_pref = 0; m_rem = 0;
            m_prod = '0; m_pend = '0; u_acc = 0; s_acc = 0;
            chk("rst_u_req_ready", 16'(bus.u_req_ready), 16'd0);
            chk("rst_s_req_ready", 16'(bus.s_req_ready), 16'd0);
            chk("rst_u_rsp_valid", 16'(bus.u_rsp_valid), 16'd0);
            chk("rst_s_rsp_valid", 16'(bus.s_rsp_valid), 16'd0);
            chk("rst_u_rsp_prod", bus.u_rsp_prod, 16'd0);
            chk("rst_s_rsp_prod", bus.s_rsp_prod, 16'd0);
            chk("rst_busy", 16'(busy), 16'd0);
            chk("rst_grant", 16'(grant_id), 16'd0);
        end else begin
            eu = !m_busy && bus.u_req_valid && (!bus.s_req_valid || !m_pref);
            es = !m_busy && bus.s_req_valid && (!bus.u_req_valid || m_pref);
            ev = m_busy && (m_rem == 0);
            chk("m_u_req_ready", 16'(bus.u_req_ready), 16'(eu));
            chk("m_s_req_ready", 16'(bus.s_req_ready), 16'(es));
            chk("m_u_rsp_valid", 16'(bus.u_rsp_valid), 16'(ev && !m_owner));
            chk("m_s_rsp_valid", 16'(bus.s_rsp_valid), 16'(ev && m_owner));
            chk("m_u_rsp_prod", bus.u_rsp_prod, m_prod);
            chk("m_s_rsp_prod", bus.s_rsp_prod, m_prod);
            chk("m_busy", 16'(busy), 16'(m_busy));
            chk("m_grant", 16'(grant_id), 16'(m_owner));
            u_acc = eu;
            s_acc = es;
            if (eu || es) begin
                m_busy  = 1;
                m_owner = es;
                m_pref  = !es;
                m_pend  = es ? 16'(bus.s_a) * 16'(bus.s_b) : 16'(bus.u_a) * 16'(bus.u_b);
                m_rem   = LAT - 1;
            end else if (m_busy && m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) m_prod = m_pend;
            end else if (ev && (m_owner ? bus.s_rsp_ready : bus.u_rsp_ready)) begin
                m_busy = 0;
            end
        end
    end

    // Drive a request; called just after a rising edge
    task automatic req(input bit spi, input logic [7:0] a, input logic [7:0] b);
        if (spi) begin bus.s_req_valid = 1'b1; bus.s_a = a; bus.s_b = b; end
        else     begin bus.u_req_valid = 1'b1; bus.u_a = a; bus.u_b = b; end
    endtask

    // Wait (bounded) for acceptance, then drop valid after the edge
    task automatic wait_accept(input bit spi, input string nm);
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = spi ? bus.s_req_ready : bus.u_req_ready;
            if (got) chk({nm, "_other_ready"}, 16'(spi ? bus.u_req_ready : bus.s_req_ready), 16'd0);
        end
        chk({nm, "_accepted"}, 16'(got), 16'd1);
        @(posedge clk); #1;
        if (spi) bus.s_req_valid = 1'b0; else bus.u_req_valid = 1'b0;
    endtask

    // Must follow wait_accept directly: checks latency, product and ownership
    task automatic wait_rsp(input bit spi, input logic [15:0] exp, input string nm);
        int k = 0;
        bit got = 0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            got = spi ? bus.s_rsp_valid : bus.u_rsp_valid;
        end
        chk({nm, "_latency"}, 16'(k), 16'(LAT));
        chk({nm, "_prod"}, spi ? bus.s_rsp_prod : bus.u_rsp_prod, exp);
        chk({nm, "_grant"}, 16'(grant_id), 16'(spi));
        chk({nm, "_nonowner_valid"}, 16'(spi ? bus.u_rsp_valid : bus.s_rsp_valid), 16'd0);
    endtask

    task automatic txn(input bit spi, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input string nm);
        req(spi, a, b);
        wait_accept(spi, nm);
        wait_rsp(spi, exp, nm);
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] rnd8();
        int unsigned r = $urandom_range(0, 7);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.u_req_valid = 0; bus.u_a = 0; bus.u_b = 0; bus.u_rsp_ready = 0;
        bus.s_req_valid = 0; bus.s_a = 0; bus.s_b = 0; bus.s_rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // UART only, ready tied high
        bus.u_rsp_ready = 1; bus.s_rsp_ready = 1;
        txn(0, 8'h0C, 8'h0A, 16'h0078, "uart_basic");

        // Both valid from reset: UART first, then SPI
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        req(0, 8'hFF, 8'hFF);
        req(1, 8'h03, 8'h05);
        wait_accept(0, "both_uart");
        wait_rsp(0, 16'hFE01, "both_uart");
        wait_accept(1, "both_spi");
        wait_rsp(1, 16'h000F, "both_spi");
        @(posedge clk); #1;

        // Backpressure on SPI while UART waits
        bus.s_rsp_ready = 0;
        req(1, 8'h80, 8'h02);
        wait_accept(1, "bp_spi");
        req(0, 8'h12, 8'h34);
        wait_rsp(1, 16'h0100, "bp_spi");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_s_rsp_valid", 16'(bus.s_rsp_valid), 16'd1);
            chk("bp_s_rsp_prod", bus.s_rsp_prod, 16'h0100);
            chk("bp_u_req_ready", 16'(bus.u_req_ready), 16'd0);
        end
        @(posedge clk); #1 bus.s_rsp_ready = 1;
        wait_accept(0, "bp_uart");
        wait_rsp(0, 16'h03A8, "bp_uart");
        @(posedge clk); #1;

        // Reset while in CALC discards the job
        req(1, 8'h55, 8'h55);
        wait_accept(1, "rst_calc");
        #2 rst_n = 1'b0;
        #1;
        chk("rstc_s_rsp_valid", 16'(bus.s_rsp_valid), 16'd0);
        chk("rstc_s_rsp_prod", bus.s_rsp_prod, 16'd0);
        chk("rstc_busy", 16'(busy), 16'd0);
        chk("rstc_grant", 16'(grant_id), 16'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rstc_no_u_rsp", 16'(bus.u_rsp_valid), 16'd0);
            chk("rstc_no_s_rsp", 16'(bus.s_rsp_valid), 16'd0);
            chk("rstc_idle", 16'(busy), 16'd0);
        end
        @(posedge clk); #1;

        // Operand extremes
        txn(0, 8'h00, 8'hB7, 16'h0000, "zero_op");
        txn(1, 8'hFF, 8'h01, 16'h00FF, "max_op");

        // Randomized traffic; the model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (u_acc || !bus.u_req_valid) begin
                bus.u_req_valid = ($urandom_range(0, 2) == 0);
                bus.u_a = rnd8();
                bus.u_b = rnd8();
            end
            if (s_acc || !bus.s_req_valid) begin
                bus.s_req_valid = ($urandom_range(0, 2) == 0);
                bus.s_a = rnd8();
                bus.s_b = rnd8();
            end
            bus.u_rsp_ready = ($urandom_range(0, 3) != 0);
            bus.s_rsp_ready = ($urandom_range(0, 3) != 0);
        end
        bus.u_req_valid = 0;
        bus.s_req_valid = 0;
        bus.u_rsp_ready = 1;
        bus.s_rsp_ready = 1;
        repeat (8) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
MUL_SHARE_CTRL -- requirements
Module: mul_share_ctrl

Interface
REQ-001 clk  input  1  rising-edge system clock; single clock domain.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 u_req_valid  input  1  UART-side operand request.
REQ-004 u_req_ready  output  1  UART request accepted when high with u_req_valid.
REQ-005 u_a, u_b  input  8 each  UART-side unsigned operands.
REQ-006 u_rsp_valid  output  1  UART-side product valid.
REQ-007 u_rsp_ready  input  1  UART side consumes product.
REQ-008 u_rsp_prod  output  16  UART-side product.
REQ-009 s_req_valid, s_req_ready, s_a, s_b, s_rsp_valid, s_rsp_ready, s_rsp_prod  SPI-side ports; same directions, widths and meanings as REQ-003..REQ-008.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 grant_id  output  1  owner of current transaction: 0 = UART, 1 = SPI; holds last owner in IDLE.

Function
REQ-012 Block SHALL time-share one instance of the 8x8 unsigned Vedic multiplier between the UART and SPI requesters.
REQ-013 FSM states: IDLE, CALC, PIPE (only with MUL_PIPE_EN), RESP.
REQ-014 IDLE: at most one req_ready high, driven combinationally from arbitration; no ready while not IDLE.
REQ-015 Arbitration: single valid wins; both valid -> requester not granted last (round-robin pointer); pointer updates on every accepted request.
REQ-016 On accept: operands registered, grant_id updated, IDLE -> CALC.
REQ-017 CALC: multiplier fed from operand registers; product registered at end of cycle; CALC -> RESP (or PIPE).
REQ-018 Latency without MUL_PIPE_EN: accept at cycle N -> owner rsp_valid high at cycle N+2.
REQ-019 RESP: only the owner's rsp_valid high; rsp_prod stable until owner rsp_ready sampled high; then RESP -> IDLE.
REQ-020 Non-owner rsp_valid SHALL stay 0; both rsp_prod outputs SHALL show the result register.
REQ-021 Product SHALL equal a*b exactly, 16-bit, no truncation; 0xFF*0xFF = 0xFE01.
REQ-022 A request arriving while busy SHALL wait (ready low); requester holds valid/operands, no loss.
REQ-023 rsp_ready asserted in the same cycle rsp_valid rises SHALL complete the response in that cycle.
REQ-024 Minimum spacing between accepts: 3 cycles (4 with MUL_PIPE_EN).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, all ready/valid 0, rsp_prod 0, operand registers 0, grant_id 0, pointer favouring UART first.
REQ-026 Reset mid-transaction SHALL discard the transaction; no response issued after release.

Configuration
REQ-027 MUL_PIPE_EN defined: PIPE state inserted after CALC, product passes one extra register stage; latency N+3.
REQ-028 MUL_PIPE_EN undefined: no PIPE state or extra register; latency N+2 per REQ-018.

Structure
REQ-029 Shared package mul_pkg SHALL hold the FSM state enum, operand width (8), product width (16) and requester ID constants (UART = 0, SPI = 1).
REQ-030 Single sub-module: the existing i8bit_mul, instantiated once; all control in mul_share_ctrl.

Verification
REQ-031 UART only, a=0x0C b=0x0A, rsp_ready tied high -> u_rsp_valid at N+2, u_rsp_prod=0x0078, s_rsp_valid stays 0.
REQ-032 Both valid together from reset (UART 0xFF*0xFF, SPI 0x03*0x05) -> UART first (0xFE01), then SPI (0x000F), grant_id 0 then 1.
REQ-033 Backpressure: SPI 0x80*0x02, s_rsp_ready low 5 cycles -> s_rsp_valid held, prod 0x0100 stable, u_req_ready 0 throughout.
REQ-034 Reset asserted during CALC -> outputs zero at once; after release no rsp_valid appears without a new request.
REQ-035 Zero and max operands: 0x00*0xB7 -> 0x0000; 0xFF*0x01 -> 0x00FF; repeat REQ-031 with MUL_PIPE_EN -> valid at N+3.
